regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between two writers, the ALU writeback (requester 0) and the load unit (requester 1), using round-robin arbitration and a valid/ready handshake. It also runs a bulk-clear sequence that writes CLEAR_VALUE to every register, one per cycle. It sits between the execution units and the register file and owns the register file's reg_write, write_reg and write_data inputs.

## Interface
- DATA_W, 8, write data width
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W (16)
- CLEAR_VALUE, 8'h00, value written to every register during a clear
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- clear_start  in  1  single-cycle request to clear all registers
- busy  out  1  high while the clear sequence runs
- req0_valid / req1_valid  in  1  requester has a write pending
- req0_reg / req1_reg  in  ADDR_W  destination register
- req0_data / req1_data  in  DATA_W  write data
- req0_ready / req1_ready  out  1  combinational; write accepted this cycle when valid && ready
- reg_write  out  1  registered write strobe to the register file
- write_reg  out  ADDR_W  registered write address
- write_data  out  DATA_W  registered write data
- grant_id  out  1  registered; source of the last arbitrated write

## Operation
- Two states: ARB and CLEAR. A 4-bit clear counter and a 1-bit last_grant pointer.
- **Reset:**
  - Clears: state ARB, last_grant 1, counter 0.
  - Outputs: reg_write 0, write_reg 0, write_data 0, grant_id 0, busy 0, both readies 0 during reset.
  - Reset asserted mid-clear aborts the clear immediately. Registers already cleared stay cleared; the rest keep their old values.
- **ARB state:**
  - If clear_start=1, both readies are 0 this cycle and the next state is CLEAR with counter 0. Clear beats pending requests.
  - Otherwise, if exactly one requester is valid, it gets ready=1.
  - If both are valid, the one that is not last_grant gets ready. This gives a strict alternation under contention; after reset, requester 0 wins the first tie.
  - On acceptance, the output register loads reg_write=1, write_reg=req_reg, write_data=req_data and grant_id=winner. last_grant also updates to the winner.
  - If nothing is accepted, reg_write loads 0. write_reg, write_data and grant_id hold their last values.
- **Both requesters target the same register:** they are serialized in arbitration order, never merged. The later write wins in the register file.
- **Requester rules:** each requester must hold valid, reg and data stable until accepted. The block never drops or reorders a requester's own writes.
- **CLEAR state:**
  - busy=1 and both readies are 0.
  - Each cycle the output register loads reg_write=1, write_reg=counter, write_data=CLEAR_VALUE, and the counter increments.
  - When counter=NUM_REGS-1 is issued, the next state is ARB and the counter wraps to 0.
  - clear_start is ignored while in CLEAR.
  - grant_id and last_grant are unchanged by a clear.

## Timing
- Write latency: a request accepted at edge-cycle T appears on reg_write/write_reg/write_data during cycle T+1 for exactly one cycle.
- Throughput: one write per cycle. Back-to-back acceptances give continuous reg_write=1.
- clear_start=1 in cycle T (state ARB):
  - busy=1 in cycles T+1..T+16.
  - reg_write=1 in cycles T+2..T+17, with write_reg 0,1,…,15 in order.
  - Readies are low from T through T+16. The earliest new acceptance is in T+17, and its write appears in T+18.
- Readies are combinational from the valids, state and last_grant. The register file sees only registered signals.

## Test plan
- **Reset values:** assert rst asynchronously mid-cycle -> all outputs 0 immediately, including busy; after release, state ARB.
- **Single requester:** req0_valid=1, reg=3, data=8'hA5 for one cycle -> req0_ready=1 that cycle; next cycle reg_write=1, write_reg=3, write_data=8'hA5, grant_id=0; the cycle after, reg_write=0.
- **Contention:** both valid continuously with distinct data, holding until accepted -> grants go 0,1,0,1; reg_write stays high every cycle after the first; each data value is written exactly once.
- **Same-register collision:** both target reg 7, req0 data 8'h11 and req1 data 8'h22, after reset -> writes 8'h11 then 8'h22 on consecutive cycles; reg 7 ends at 8'h22.
- **Clear:**
  - clear_start pulsed with req1_valid=1 in the same cycle -> req1 is not accepted; 16 writes of 8'h00 to addresses 0..15; busy is high for 16 cycles.
  - req1 is accepted in the first cycle after busy falls.
  - A second clear_start pulse during the clear has no effect.
- **Reset mid-clear:** assert rst after 5 clear writes -> outputs 0 and busy 0; after release, ARB resumes and accepts a request normally.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: round-robin sharing between the ALU
// writeback (requester 0) and the load unit (requester 1), plus a bulk-clear
// sequence that writes CLEAR_VALUE to every register, one per cycle.
module regfile_write_arbiter #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_start_i,
    output logic              busy_o,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_reg_i,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_reg_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req0_ready_o,
    output logic              req1_ready_o,
    output logic              reg_write_o,
    output logic [ADDR_W-1:0] write_reg_o,
    output logic [DATA_W-1:0] write_data_o,
    output logic              grant_id_o
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_REG = {ADDR_W{1'b1}};

    state_t            state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              last_grant_q;
    logic              reg_write_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0] write_data_q;
    logic              grant_id_q;

    logic can_accept;
    logic ready0;
    logic ready1;
    logic accept0;
    logic accept1;

    // Combinational readies: a pending clear (or reset) blocks both requesters;
    // on a tie the requester that did not win last time gets the port.
    always_comb begin
        can_accept = (state_q == ST_ARB) && !rst_i && !clear_start_i;
        ready0     = can_accept && req0_valid_i && (!req1_valid_i || last_grant_q);
        ready1     = can_accept && req1_valid_i && (!req0_valid_i || !last_grant_q);
        accept0    = req0_valid_i && ready0;
        accept1    = req1_valid_i && ready1;
    end

    // Control FSM and the registered write port seen by the register file.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_ARB;
            clr_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            grant_id_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (clear_start_i) begin
                        state_q     <= ST_CLEAR;
                        clr_cnt_q   <= '0;
                        reg_write_q <= 1'b0;
                    end else if (accept0) begin
                        reg_write_q  <= 1'b1;
                        write_reg_q  <= req0_reg_i;
                        write_data_q <= req0_data_i;
                        grant_id_q   <= 1'b0;
                        last_grant_q <= 1'b0;
                    end else if (accept1) begin
                        reg_write_q  <= 1'b1;
                        write_reg_q  <= req1_reg_i;
                        write_data_q <= req1_data_i;
                        grant_id_q   <= 1'b1;
                        last_grant_q <= 1'b1;
                    end else begin
                        reg_write_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    // Clear starts are ignored here; the sweep always runs to the end.
                    reg_write_q  <= 1'b1;
                    write_reg_q  <= clr_cnt_q;
                    write_data_q <= CLEAR_VALUE;
                    clr_cnt_q    <= clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == LAST_REG) begin
                        state_q <= ST_ARB;
                    end
                end
                default: begin
                    state_q     <= ST_ARB;
                    reg_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = (state_q == ST_CLEAR);
    assign req0_ready_o = ready0;
    assign req1_ready_o = ready1;
    assign reg_write_o  = reg_write_q;
    assign write_reg_o  = write_reg_q;
    assign write_data_o = write_data_q;
    assign grant_id_o   = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed stimulus pushes the
// hand-computed expected write for each cycle, a monitor pops and compares.
module tb_regfile_write_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_start = 1'b0;
    logic       busy;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_reg = '0;
    logic [7:0] req0_data = '0;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_reg = '0;
    logic [7:0] req1_data = '0;
    logic       req0_ready;
    logic       req1_ready;
    logic       reg_write;
    logic [3:0] write_reg;
    logic [7:0] write_data;
    logic       grant_id;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
        logic       g;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] rf [16];
    int         checks = 0;
    int         errors = 0;

    regfile_write_arbiter #(.DATA_W(8), .ADDR_W(4), .CLEAR_VALUE(8'h00)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_start_i (clear_start),
        .busy_o        (busy),
        .req0_valid_i  (req0_valid),
        .req0_reg_i    (req0_reg),
        .req0_data_i   (req0_data),
        .req1_valid_i  (req1_valid),
        .req1_reg_i    (req1_reg),
        .req1_data_i   (req1_data),
        .req0_ready_o  (req0_ready),
        .req1_ready_o  (req1_ready),
        .reg_write_o   (reg_write),
        .write_reg_o   (write_reg),
        .write_data_o  (write_data),
        .grant_id_o    (grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, check the
    // combinational readies/busy, and queue the write expected next edge.
    task automatic step(input logic v0, input logic [3:0] a0, input logic [7:0] d0,
                        input logic v1, input logic [3:0] a1, input logic [7:0] d1,
                        input logic clr, input logic er0, input logic er1, input logic ebusy,
                        input logic ew, input logic [3:0] ereg, input logic [7:0] edata,
                        input logic egid);
        wr_t w;
        @(negedge clk);
        req0_valid = v0; req0_reg = a0; req0_data = d0;
        req1_valid = v1; req1_reg = a1; req1_data = d1;
        clear_start = clr;
        #1;
        check("req0_ready", 32'(req0_ready), 32'(er0));
        check("req1_ready", 32'(req1_ready), 32'(er1));
        check("busy", 32'(busy), 32'(ebusy));
        if (ew) begin
            w.a = ereg; w.d = edata; w.g = egid;
            exp_q.push_back(w);
        end
    endtask

    task automatic idle();
        step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00, 0);
    endtask

    // Assert reset asynchronously mid-cycle with both requesters valid.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_write_reg", 32'(write_reg), 32'd0);
        check("rst_write_data", 32'(write_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; clear_start = 1'b0;
    endtask

    // Monitor: after each rising edge, pop the expected write (if any) and compare.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_strobe", 32'(reg_write), 32'd1);
                check("wr_reg", 32'(write_reg), 32'(e.a));
                check("wr_data", 32'(write_data), 32'(e.d));
                check("wr_grant", 32'(grant_id), 32'(e.g));
                if (reg_write === 1'b1) rf[write_reg] = write_data;
                $display("write reg=%0d data=%02h grant=%0d (exp reg=%0d data=%02h grant=%0d)",
                         write_reg, write_data, grant_id, e.a, e.d, e.g);
            end else begin
                check("idle_strobe", 32'(reg_write), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single requester, then the strobe drops.
        step(1, 4'd3, 8'hA5, 0, 4'd0, 8'h00, 0, 1, 0, 0, 1, 4'd3, 8'hA5, 0);
        idle();
        idle();

        // Mid-cycle reset clears the registered outputs immediately.
        apply_reset();

        // Contention: both held valid, alternating 0,1,0,1.
        step(1, 4'd1, 8'h10, 1, 4'd2, 8'h20, 0, 1, 0, 0, 1, 4'd1, 8'h10, 0);
        step(1, 4'd1, 8'h11, 1, 4'd2, 8'h20, 0, 0, 1, 0, 1, 4'd2, 8'h20, 1);
        step(1, 4'd1, 8'h11, 1, 4'd2, 8'h21, 0, 1, 0, 0, 1, 4'd1, 8'h11, 0);
        step(1, 4'd1, 8'h12, 1, 4'd2, 8'h21, 0, 0, 1, 0, 1, 4'd2, 8'h21, 1);
        idle();

        // Same-register collision after reset: 0x11 then 0x22 to reg 7.
        apply_reset();
        step(1, 4'd7, 8'h11, 1, 4'd7, 8'h22, 0, 1, 0, 0, 1, 4'd7, 8'h11, 0);
        step(0, 4'd0, 8'h00, 1, 4'd7, 8'h22, 0, 0, 1, 0, 1, 4'd7, 8'h22, 1);
        idle();
        check("rf7_after_collision", 32'(rf[7]), 32'h22);

        // Clear with req1 pending; a second pulse mid-clear is ignored.
        step(0, 4'd0, 8'h00, 1, 4'd9, 8'h5A, 1, 0, 0, 0, 0, 4'd0, 8'h00, 0);
        for (int k = 0; k < 16; k++) begin
            step(0, 4'd0, 8'h00, 1, 4'd9, 8'h5A, (k == 2), 0, 0, 1, 1, 4'(k), 8'h00, 1);
        end
        step(0, 4'd0, 8'h00, 1, 4'd9, 8'h5A, 0, 0, 1, 0, 1, 4'd9, 8'h5A, 1);
        idle();
        check("rf7_after_clear", 32'(rf[7]), 32'h00);

        // Reset mid-clear after five clear writes.
        step(1, 4'd10, 8'h77, 0, 4'd0, 8'h00, 0, 1, 0, 0, 1, 4'd10, 8'h77, 0);
        step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 1, 0, 0, 0, 0, 4'd0, 8'h00, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0, 1, 1, 4'(k), 8'h00, 0);
        end
        apply_reset();
        check("rf10_kept", 32'(rf[10]), 32'h77);
        check("rf4_cleared", 32'(rf[4]), 32'h00);
        step(1, 4'd12, 8'hC3, 0, 4'd0, 8'h00, 0, 1, 0, 0, 1, 4'd12, 8'hC3, 0);
        idle();
        idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
